// File: rtl/rf_pkg.sv
// rf_pkg: register-file geometry shared with the register file, plus the
// state encoding of the rf_scan_reader sweep FSM.
package rf_pkg;

  localparam int unsigned RF_AW       = 3;
  localparam int unsigned RF_DW       = 32;
  localparam int unsigned RF_NUM_REGS = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } scan_state_t;

endpackage

// File: rtl/rf_scan_reader.sv
// rf_scan_reader: on start, sweeps register-file addresses 0..NUM_REGS-1,
// captures each word and streams it out on a valid/ready handshake.
// Optional feature macro RF_SCAN_CHECKSUM_EN appends an XOR checksum word
// after the last register; without it out_csum stays 0.
module rf_scan_reader
  import rf_pkg::*;
#(
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic [AW-1:0] rf_rAddr,
  input  logic [DW-1:0] rf_rData,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          out_csum,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

`ifdef RF_SCAN_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  logic [DW-1:0] acc, acc_d;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  scan_state_t   state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic          valid_d, last_d, csum_d, busy_d, done_d;
  logic [DW-1:0] data_d;
  logic [AW-1:0] index_d;
  logic          hs;

  assign rf_rAddr = idx;
  assign hs       = out_valid && out_ready;

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    valid_d = out_valid;
    data_d  = out_data;
    index_d = out_index;
    last_d  = out_last;
    csum_d  = out_csum;
`ifdef RF_SCAN_CHECKSUM_EN
    acc_d   = acc;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = ST_READ;
`ifdef RF_SCAN_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      ST_READ: begin
        data_d  = rf_rData;
        index_d = idx;
        valid_d = 1'b1;
        last_d  = (idx == LAST_IDX) && !CSUM_EN;
        csum_d  = 1'b0;
        state_d = ST_SEND;
`ifdef RF_SCAN_CHECKSUM_EN
        acc_d   = acc ^ rf_rData;
`endif
      end
      ST_SEND: begin
        if (hs) begin
          valid_d = 1'b0;
          if (idx != LAST_IDX) begin
            idx_d   = idx + AW'(1);
            state_d = ST_READ;
          end else begin
`ifdef RF_SCAN_CHECKSUM_EN
            // Checksum word is loaded on this edge so it costs one cycle.
            valid_d = 1'b1;
            data_d  = acc;
            index_d = LAST_IDX;
            last_d  = 1'b1;
            csum_d  = 1'b1;
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        last_d  = 1'b0;
        csum_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_csum  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_index <= index_d;
      out_last  <= last_d;
      out_csum  <= csum_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

`ifdef RF_SCAN_CHECKSUM_EN
  // XOR accumulator of every word captured in the current sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc <= '0;
    else          acc <= acc_d;
  end
`endif

endmodule

// File: tb/tb_rf_scan_reader.sv
// tb_rf_scan_reader: self-checking bench for rf_scan_reader with a
// behavioural register file and an expected-stream model.
module tb_rf_scan_reader;
  import rf_pkg::*;

  localparam int unsigned AW = RF_AW;
  localparam int unsigned DW = RF_DW;
  localparam int unsigned N  = RF_NUM_REGS;
`ifdef RF_SCAN_CHECKSUM_EN
  localparam int unsigned CS = 1;
`else
  localparam int unsigned CS = 0;
`endif

  typedef struct packed {
    logic          csum;
    logic          last;
    logic [AW-1:0] index;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rf_rAddr;
  logic [DW-1:0] rf_rData;
  logic          out_valid, out_last, out_csum, busy, done;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;

  logic [DW-1:0] rf [N];
  word_t         got_q[$];
  word_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            done_cnt = 0;

  rf_scan_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rf_rAddr  (rf_rAddr),
    .rf_rData  (rf_rData),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_csum  (out_csum),
    .busy      (busy),
    .done      (done)
  );

  assign rf_rData = rf[rf_rAddr];

  always #5 clk = ~clk;

  // Record accepted words and done pulses mid-cycle.
  always @(negedge clk) begin
    word_t w;
    if (out_valid && out_ready) begin
      w = {out_csum, out_last, out_index, out_data};
      got_q.push_back(w);
    end
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected stream: every register in address order, then the XOR word.
  function automatic void build_expected;
    word_t         w;
    logic [DW-1:0] x;
    exp_q.delete();
    x = '0;
    for (int i = 0; i < int'(N); i++) begin
      x       = x ^ rf[i];
      w.data  = rf[i];
      w.index = AW'(i);
      w.last  = (i == int'(N) - 1) && (CS == 0);
      w.csum  = 1'b0;
      exp_q.push_back(w);
    end
    if (CS != 0) begin
      w = {1'b1, 1'b1, AW'(N - 1), x};
      exp_q.push_back(w);
    end
  endfunction

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < budget && !ok) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      tick;
      cyc++;
      if (done) ok = 1'b1;
    end
    out_ready = 1'b1;
  endtask

  task automatic wait_word(input int idx, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 100 && !ok) begin
      if (out_valid && out_index == AW'(idx) && !out_csum) ok = 1'b1;
      else begin
        tick;
        n++;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < int'(N); i++) rf[i] = '0;
    tick;
    tick;
    checks++;
    if ({out_valid, out_data, out_index, out_last, out_csum, busy, done, rf_rAddr} !== '0) begin
      errors++;
      $display("FAIL reset_values: valid=%b data=%h index=%0d last=%b csum=%b busy=%b done=%b addr=%0d, all must be 0",
               out_valid, out_data, out_index, out_last, out_csum, busy, done, rf_rAddr);
    end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int cyc;
    bit ok;
    rf[0] = 32'habcd1234;
    rf[1] = 32'h1234cdef;
    rf[3] = 32'hf9876543;
    rf[7] = 32'hffffaaaa;
    got_q.delete();
    out_ready = 1'b1;
    pulse_start;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || rf_rAddr !== '0) begin
      errors++;
      $display("FAIL basic_read_cycle: valid=%b busy=%b addr=%0d, required 0/1/0", out_valid, busy, rf_rAddr);
    end
    wait_done(100, 1'b0, cyc, ok);
    checks++;
    if (!ok || cyc != 2 * int'(N) + int'(CS)) begin
      errors++;
      $display("FAIL basic_latency: done after %0d cycles (seen=%b), required %0d", cyc, ok, 2 * int'(N) + int'(CS));
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: done=%b busy=%b one cycle later, required 0/0", done, busy);
    end
    build_expected();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() > 7 && (got_q[7].data !== 32'hffffaaaa || got_q[7].last !== (CS == 0))) begin
      errors++;
      $display("FAIL basic_last_word: data=%h last=%b", got_q[7].data, got_q[7].last);
    end
`ifdef RF_SCAN_CHECKSUM_EN
    checks++;
    if (got_q.size() <= int'(N) || got_q[N].data !== 32'hbf811032 || got_q[N].csum !== 1'b1 || got_q[N].last !== 1'b1) begin
      errors++;
      $display("FAIL basic_checksum: size=%0d, required word %h csum=1 last=1", got_q.size(), 32'hbf811032);
    end
`endif
  endtask

  task automatic test_backpressure;
    int cyc;
    bit seen;
    got_q.delete();
    out_ready = 1'b1;
    seen = 1'b0;
    cyc = 0;
    pulse_start;
    while (cyc < 100 && !done) begin
      if (!seen && out_valid && out_index == AW'(3)) begin
        seen = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick;
          cyc++;
          checks++;
          if (out_valid !== 1'b1 || out_data !== 32'hf9876543 || out_index !== AW'(3) || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b data=%h index=%0d last=%b, required 1/f9876543/3/0",
                     k, out_valid, out_data, out_index, out_last);
          end
        end
        out_ready = 1'b1;
      end else begin
        tick;
        cyc++;
      end
    end
    checks++;
    if (!seen || !done || cyc != 2 * int'(N) + int'(CS) + 5) begin
      errors++;
      $display("FAIL bp_latency: done=%b after %0d cycles, required %0d", done, cyc, 2 * int'(N) + int'(CS) + 5);
    end
    tick;
    build_expected();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_busy;
    int cyc;
    bit ok;
    int d0;
    got_q.delete();
    out_ready = 1'b1;
    d0 = done_cnt;
    pulse_start;
    wait_word(2, ok);
    pulse_start;
    wait_done(100, 1'b0, cyc, ok);
    repeat (40) tick;
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_done: %0d done pulses busy=%b, required 1 pulse busy=0", done_cnt - d0, busy);
    end
    build_expected();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL busy_start_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL busy_start_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    int d0;
    got_q.delete();
    out_ready = 1'b1;
    d0 = done_cnt;
    pulse_start;
    wait_word(4, ok);
    reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || {out_valid, out_data, out_index, out_last, out_csum, busy, done, rf_rAddr} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: valid=%b data=%h index=%0d last=%b busy=%b addr=%0d, all must be 0",
               out_valid, out_data, out_index, out_last, busy, rf_rAddr);
    end
    tick;
    reset_n = 1'b1;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL rst_mid_idle: busy=%b valid=%b done pulses=%0d, required 0/0/0", busy, out_valid, done_cnt - d0);
    end
    got_q.delete();
    pulse_start;
    wait_done(100, 1'b0, cyc, ok);
    tick;
    build_expected();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rst_mid_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_mid_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_write_during;
    int cyc;
    bit ok;
    got_q.delete();
    out_ready = 1'b1;
    pulse_start;
    wait_word(2, ok);
    rf[6] = 32'h5a5a5a5a;
    wait_done(100, 1'b0, cyc, ok);
    tick;
    checks++;
    if (got_q.size() < 7 || got_q[6].data !== 32'h5a5a5a5a) begin
      errors++;
      $display("FAIL write_during_idx6: got %h, required 5a5a5a5a", got_q.size() > 6 ? got_q[6].data : '0);
    end
    build_expected();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL write_during_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    int cyc;
    bit ok;
    int d0;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < int'(N); i++) rf[i] = $urandom;
      got_q.delete();
      d0 = done_cnt;
      pulse_start;
      wait_done(400, 1'b1, cyc, ok);
      tick;
      build_expected();
      checks++;
      if (!ok || done_cnt - d0 != 1 || got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_sweep: done=%b pulses=%0d words=%0d, required 1/1/%0d",
                 it, ok, done_cnt - d0, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_word%0d: got %h, required %h", it, i, got_q[i], exp_q[i]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        out_ready = $urandom_range(0, 1);
        tick;
      end
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_idle_ready: valid=%b busy=%b words=%0d, required 0/0/%0d",
                 it, out_valid, busy, got_q.size(), exp_q.size());
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_start_busy;
    test_reset_mid;
    test_write_during;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
